// File: rtl/clk_div_ctrl.sv
// Run-time divided-clock controller: start/stop sequencing plus glitch-free
// divide-ratio updates that only take effect on a falling half-period boundary.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clkIn,
  input  logic             rstIn,
  input  logic             startIn,
  input  logic             stopIn,
  input  logic             divValidIn,
  input  logic [CNT_W-1:0] divIn,
  output logic             divReadyOut,
  output logic             clkOut,
  output logic             clkEnOut,
  output logic             busyOut,
  output logic [CNT_W-1:0] divActiveOut,
  output logic             errOut
);

  // state    | meaning
  // IDLE     | clkOut held low, counter cleared, waiting for start
  // RUN      | counting half-periods and toggling clkOut
  // STOPPING | finishing the current high phase, then back to IDLE
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} stateT;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  logic             pendValid;
  logic [CNT_W-1:0] pendVal;

  logic lastCnt;
  logic fallToggle;
  logic goIdle;
  logic applySlot;
  logic accept;
  logic acceptOk;

  always_comb begin
    lastCnt    = (cnt == divActiveOut - ONE);
    fallToggle = (state != IDLE) && clkOut && lastCnt;
    goIdle     = ((state == RUN) && stopIn && (!clkOut || fallToggle)) ||
                 ((state == STOPPING) && fallToggle);
    applySlot  = fallToggle || goIdle;
    accept     = divValidIn && !pendValid;
    acceptOk   = accept && (divIn != '0);
  end

  assign divReadyOut = !pendValid;
  assign busyOut     = (state != IDLE);

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state        <= IDLE;
      cnt          <= '0;
      clkOut       <= 1'b0;
      clkEnOut     <= 1'b0;
      divActiveOut <= CNT_W'(DEFAULT_DIV);
      pendValid    <= 1'b0;
      pendVal      <= '0;
      errOut       <= 1'b0;
    end else begin
      clkEnOut <= 1'b0;

      // Slot apply and a new acceptance are mutually exclusive: accept needs an empty slot.
      if (applySlot && pendValid) begin
        divActiveOut <= pendVal;
        pendValid    <= 1'b0;
      end
      if (accept && (divIn == '0))
        errOut <= 1'b1;
      if (acceptOk) begin
        if ((state == IDLE) || goIdle) begin
          divActiveOut <= divIn;
        end else begin
          pendValid <= 1'b1;
          pendVal   <= divIn;
        end
      end

      case (state)
        IDLE: begin
          cnt    <= '0;
          clkOut <= 1'b0;
          if (startIn && !stopIn)
            state <= RUN;
        end
        RUN: begin
          if (stopIn && !clkOut) begin
            // Truncating a low phase produces no edge, so stopping here is safe.
            state <= IDLE;
            cnt   <= '0;
          end else if (lastCnt) begin
            cnt    <= '0;
            clkOut <= !clkOut;
            if (!clkOut)
              clkEnOut <= 1'b1;
            else if (stopIn)
              state <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            if (stopIn)
              state <= STOPPING;
          end
        end
        STOPPING: begin
          if (lastCnt) begin
            cnt    <= '0;
            clkOut <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          clkOut <= 1'b0;
        end
      endcase
    end
  end

endmodule
